seq_signed_divider: RTL



---
 rtl/seq_signed_divider_if.sv | 23 ++
 rtl/seq_signed_divider.sv | 116 +++++++++++
 2 files changed

// File: rtl/seq_signed_divider_if.sv
// Operand/result bundle for the sequential signed divider.
// The requester drives start/operands; the divider returns status and results.
interface seq_signed_divider_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: one restoring step per clock on operand magnitudes,
// followed by a single sign-fix cycle that publishes results and pulses done.
module seq_signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    seq_signed_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qreg, dmag, dvd_raw;
    logic             sign_q, sign_r, dz_pend, ovf_pend;
    logic             busy_r, done_r, dz_r, ovf_r;
    logic [WIDTH-1:0] quot_r, rem_r;
    logic [WIDTH:0]   shifted, trial;

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.divisor == '0) ? FIX : CALC;
            CALC:    if (count == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)   state <= IDLE;
        else if (ena) state <= state_nxt;
    end

    // One restoring step: shift the next dividend bit into the partial remainder
    always_comb begin
        shifted = {prem[WIDTH-1:0], qreg[WIDTH-1]};
        trial   = shifted - {1'b0, dmag};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            prem     <= '0;
            qreg     <= '0;
            dmag     <= '0;
            dvd_raw  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            ovf_r    <= 1'b0;
            quot_r   <= '0;
            rem_r    <= '0;
        end else if (ena) begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    sign_r   <= bus.dividend[WIDTH-1];
                    // Negating the most negative value yields 2^(WIDTH-1), correct as unsigned
                    qreg     <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                    dmag     <= bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
                    dvd_raw  <= bus.dividend;
                    dz_pend  <= (bus.divisor == '0);
                    ovf_pend <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                    prem     <= '0;
                    count    <= CW'(WIDTH);
                    busy_r   <= 1'b1;
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        prem <= trial;
                        qreg <= {qreg[WIDTH-2:0], 1'b1};
                    end else begin
                        prem <= shifted;
                        qreg <= {qreg[WIDTH-2:0], 1'b0};
                    end
                    count <= count - CW'(1);
                end
                FIX: begin
                    if (dz_pend) begin
                        quot_r <= '1;
                        rem_r  <= dvd_raw;
                        dz_r   <= 1'b1;
                        ovf_r  <= 1'b0;
                    end else begin
                        quot_r <= sign_q ? -qreg : qreg;
                        rem_r  <= sign_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                        dz_r   <= 1'b0;
                        ovf_r  <= ovf_pend;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;
    assign bus.overflow    = ovf_r;
endmodule
